// File: rtl/insn_encode_pkg.sv
// Shared RV32I opcode/funct3 constants and record types for the encode path.
// Used by insn_encode (optional IMM_CHECK_EN build) and its FIFO.
package insn_encode_pkg;

    localparam int INSN_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SRX  = 3'b101;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [INSN_W-1:0] imm;
    } insn_fields_t;

    typedef struct packed {
        logic [INSN_W-1:0] insn;
        logic [ADDR_W-1:0] addr;
    } enc_entry_t;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } insn_fmt_t;

    // Shift-immediates share OP_IMM with ordinary I-type but carry funct7.
    function automatic insn_fmt_t fmt_of(input logic [6:0] op, input logic [2:0] f3);
        insn_fmt_t fmt;
        case (op)
            OP_REG:                      fmt = FMT_R;
            OP_IMM:                      fmt = (f3 == F3_SLL || f3 == F3_SRX) ? FMT_SH : FMT_I;
            OP_LOAD, OP_JALR, OP_SYSTEM: fmt = FMT_I;
            OP_STORE:                    fmt = FMT_S;
            OP_BRANCH:                   fmt = FMT_B;
            OP_LUI, OP_AUIPC:            fmt = FMT_U;
            OP_JAL:                      fmt = FMT_J;
            default:                     fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/insn_encode_fifo.sv
// Synchronous FIFO of encoded {insn, addr} entries; reset flushes all entries.
// Used by insn_encode (IMM_CHECK_EN does not affect this file).
module insn_enc_fifo
    import insn_encode_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  enc_entry_t wr_data,
    input  logic       pop,
    output enc_entry_t rd_data,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);

    enc_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   used;
    logic          do_push;
    logic          do_pop;

    assign full    = (used == (PW+1)'(DEPTH));
    assign empty   = (used == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

endmodule

// File: rtl/insn_encode.sv
// RV32I field-set to instruction-word encoder with address tagging and output FIFO.
// Define IMM_CHECK_EN to reject out-of-range immediates instead of truncating them.
module insn_encode
    import insn_encode_pkg::*;
#(
    parameter int                DWIDTH    = 32,
    parameter int                AWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
    parameter int                DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [DWIDTH-1:0] imm_i,
    input  logic              addr_load_i,
    input  logic [AWIDTH-1:0] addr_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] insn_o,
    output logic [AWIDTH-1:0] addr_o,
    output logic              err_o,
    output logic [15:0]       count_o
);

    insn_fields_t      f;
    insn_fmt_t         fmt;
    logic [INSN_W-1:0] enc;
    logic [INSN_W-1:0] imm;
    logic              imm_ok;
    logic              enc_ok;
    logic              accept;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [AWIDTH-1:0] addr_cnt;
    logic [AWIDTH-1:0] addr_cur;
    enc_entry_t        wr_entry;
    enc_entry_t        head;

    assign f = '{opcode: opcode_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i,
                 funct3: funct3_i, funct7: funct7_i, imm: imm_i};
    assign imm = f.imm;

    always_comb begin
        fmt    = fmt_of(f.opcode, f.funct3);
        enc    = '0;
        imm_ok = 1'b1;
        case (fmt)
            FMT_R:   enc = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            FMT_I:   enc = {imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            FMT_SH:  enc = {f.funct7, imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
            FMT_S:   enc = {imm[11:5], f.rs2, f.rs1, f.funct3, imm[4:0], f.opcode};
            FMT_B:   enc = {imm[12], imm[10:5], f.rs2, f.rs1, f.funct3, imm[4:1], imm[11], f.opcode};
            FMT_U:   enc = {imm[31:12], f.rd, f.opcode};
            FMT_J:   enc = {imm[20], imm[10:1], imm[11], imm[19:12], f.rd, f.opcode};
            default: enc = '0;
        endcase
`ifdef IMM_CHECK_EN
        case (fmt)
            FMT_I, FMT_S: imm_ok = (imm == {{20{imm[11]}}, imm[11:0]});
            FMT_B:        imm_ok = (imm == {{19{imm[12]}}, imm[12:0]}) && !imm[0];
            FMT_J:        imm_ok = (imm == {{11{imm[20]}}, imm[20:0]}) && !imm[0];
            FMT_U:        imm_ok = (imm[11:0] == 12'h000);
            FMT_SH:       imm_ok = (imm[31:5] == 27'h0);
            default:      imm_ok = 1'b1;
        endcase
`endif
        enc_ok = (fmt != FMT_BAD) && imm_ok;
    end

    // A full FIFO blocks input even if the head is popped in the same cycle.
    assign in_ready_o = !full;
    assign accept     = in_valid_i && in_ready_o;
    assign push       = accept && enc_ok;
    assign pop        = out_valid_o && out_ready_i;
    assign addr_cur   = addr_load_i ? addr_i : addr_cnt;
    assign wr_entry   = '{insn: enc, addr: addr_cur};

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_cnt <= BASE_ADDR;
            err_o    <= 1'b0;
            count_o  <= '0;
        end else begin
            if (push) begin
                addr_cnt <= addr_cur + AWIDTH'(4);
            end else if (addr_load_i) begin
                addr_cnt <= addr_i;
            end
            err_o <= accept && !enc_ok;
            if (pop) begin
                count_o <= count_o + 16'd1;
            end
        end
    end

    insn_enc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign out_valid_o = !empty;
    assign insn_o      = empty ? '0 : head.insn;
    assign addr_o      = empty ? '0 : head.addr;

endmodule

// File: tb/tb_insn_encode.sv
// Self-checking bench for insn_encode: vector table plus hand sequences, scoreboard on the output port.
module tb_insn_encode;
    import insn_encode_pkg::*;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam int NV = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [6:0]  opcode_i = '0;
    logic [4:0]  rd_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [31:0] imm_i = '0;
    logic        addr_load_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] insn_o;
    logic [31:0] addr_o;
    logic        err_o;
    logic [15:0] count_o;

    always #5 clk = ~clk;

    insn_encode #(.DWIDTH(32), .AWIDTH(32), .BASE_ADDR(BASE), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
        .addr_load_i(addr_load_i), .addr_i(addr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .insn_o(insn_o), .addr_o(addr_o), .err_o(err_o), .count_o(count_o)
    );

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp;
        bit          err;
    } vec_t;

    vec_t        vt [NV];
    int          checks = 0;
    int          failures = 0;
    enc_entry_t  sb_q [$];
    enc_entry_t  mon_e;
    logic [31:0] addr_m = BASE;
    logic [15:0] cnt_m = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Pops are sampled mid-cycle; the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst && out_valid_o && out_ready_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %08h@%08h expected none", insn_o, addr_o);
            end else begin
                mon_e = sb_q.pop_front();
                check32("pop_insn", insn_o, mon_e.insn);
                check32("pop_addr", addr_o, mon_e.addr);
            end
            check32("count_o", 32'(count_o), 32'(cnt_m));
            cnt_m = cnt_m + 16'd1;
        end
    end

    task automatic drive(input vec_t v, input bit ld, input logic [31:0] ld_addr);
        bit          done = 1'b0;
        logic [31:0] a;
        opcode_i = v.op; rd_i = v.rd; rs1_i = v.rs1; rs2_i = v.rs2;
        funct3_i = v.f3; funct7_i = v.f7; imm_i = v.imm;
        addr_load_i = ld; addr_i = ld_addr; in_valid_i = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (in_ready_o) begin
                done = 1'b1;
                a = ld ? ld_addr : addr_m;
                if (!v.err) begin
                    sb_q.push_back('{insn: v.exp, addr: a});
                    addr_m = a + 32'd4;
                end else begin
                    addr_m = a;
                end
            end
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        addr_load_i = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready_o=0 for 200 cycles expected accept");
        end else begin
            check32("err_o", 32'(err_o), 32'(v.err));
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || out_valid_o) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d entries pending expected 0", sb_q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid_i = 1'b0;
        addr_load_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.delete();
        addr_m = BASE;
        cnt_m = '0;
    endtask

    initial begin
        vt[0]  = '{7'h33, 5'd3,  5'd1,  5'd2, 3'd0, 7'h00, 32'h0000_0000, 32'h0020_81B3, 1'b0};
        vt[1]  = '{7'h13, 5'd1,  5'd0,  5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0};
        vt[2]  = '{7'h63, 5'd0,  5'd1,  5'd2, 3'd0, 7'h00, 32'h0000_0008, 32'h0020_8463, 1'b0};
        vt[3]  = '{7'h33, 5'd5,  5'd6,  5'd7, 3'd0, 7'h20, 32'h0000_0000, 32'h4073_02B3, 1'b0};
        vt[4]  = '{7'h13, 5'd10, 5'd11, 5'd0, 3'd5, 7'h20, 32'h0000_0003, 32'h4035_D513, 1'b0};
        vt[5]  = '{7'h23, 5'd0,  5'd1,  5'd2, 3'd2, 7'h00, 32'h0000_000C, 32'h0020_A623, 1'b0};
        vt[6]  = '{7'h37, 5'd5,  5'd0,  5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0};
        vt[7]  = '{7'h03, 5'd4,  5'd2,  5'd0, 3'd2, 7'h00, 32'hFFFF_FFFC, 32'hFFC1_2203, 1'b0};
        vt[8]  = '{7'h67, 5'd0,  5'd1,  5'd0, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_8067, 1'b0};
        vt[9]  = '{7'h17, 5'd1,  5'd0,  5'd0, 3'd0, 7'h00, 32'h0000_1000, 32'h0000_1097, 1'b0};
        vt[10] = '{7'h63, 5'd0,  5'd1,  5'd2, 3'd1, 7'h00, 32'hFFFF_FFFC, 32'hFE20_9EE3, 1'b0};
        vt[11] = '{7'h6F, 5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'hFFFF_FFF8, 32'hFF9F_F06F, 1'b0};
        vt[12] = '{7'h73, 5'd0,  5'd0,  5'd0, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_0073, 1'b0};
        vt[13] = '{7'h7F, 5'd1,  5'd2,  5'd3, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vt[14] = '{7'h13, 5'd1,  5'd1,  5'd0, 3'd1, 7'h00, 32'h0000_001F, 32'h01F0_9093, 1'b0};
`ifdef IMM_CHECK_EN
        vt[15] = '{7'h13, 5'd1,  5'd0,  5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0000_0000, 1'b1};
`else
        vt[15] = '{7'h13, 5'd1,  5'd0,  5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h8000_0093, 1'b0};
`endif

        repeat (2) @(posedge clk);
        #1;
        check32("rst_out_valid", 32'(out_valid_o), 32'd0);
        check32("rst_in_ready", 32'(in_ready_o), 32'd1);
        check32("rst_insn", insn_o, 32'h0);
        check32("rst_addr", addr_o, 32'h0);
        check32("rst_err", 32'(err_o), 32'd0);
        check32("rst_count", 32'(count_o), 32'd0);
        rst = 1'b1;

        // add: visible one cycle after accept at the base address
        out_ready_i = 1'b1;
        drive(vt[0], 1'b0, 32'h0);
        check32("latency_valid", 32'(out_valid_o), 32'd1);
        check32("first_insn", insn_o, 32'h0020_81B3);
        check32("first_addr", addr_o, 32'h0100_0000);
        drive(vt[1], 1'b0, 32'h0);
        drive(vt[2], 1'b0, 32'h0);
        drain();

        // jal with address reload; next word follows the reloaded address
        drive('{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 1'b0},
              1'b1, 32'h0000_FFFC);
        check32("jal_insn", insn_o, 32'h0010_00EF);
        check32("jal_addr", addr_o, 32'h0000_FFFC);
        drain();
        drive(vt[0], 1'b0, 32'h0);
        check32("after_load_addr", addr_o, 32'h0001_0000);
        drain();

        // unsupported opcode: pulse, no output, counter untouched
        drive(vt[13], 1'b0, 32'h0);
        check32("bad_no_output", 32'(out_valid_o), 32'd0);
        @(posedge clk); #1;
        check32("err_one_cycle", 32'(err_o), 32'd0);
        drive(vt[0], 1'b0, 32'h0);
        check32("bad_addr_kept", addr_o, 32'h0001_0004);
        drain();

        for (int i = 0; i < NV; i++) begin
            out_ready_i = ($urandom_range(0, 3) != 0);
            drive(vt[i], 1'b0, 32'h0);
        end
        out_ready_i = 1'b1;
        drain();

        // backpressure: four words fill the FIFO, fifth waits for a pop
        do_reset();
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) drive(vt[i], 1'b0, 32'h0);
        check32("full_in_ready", 32'(in_ready_o), 32'd0);
        fork
            drive(vt[4], 1'b0, 32'h0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check32("held_in_ready", 32'(in_ready_o), 32'd0);
                    check32("stable_insn", insn_o, 32'h0020_81B3);
                end
                @(posedge clk); #1;
                out_ready_i = 1'b1;
            end
        join
        drain();
        check32("count_after_5", 32'(count_o), 32'd5);

        // mid-stream reset discards queued words
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) drive(vt[i], 1'b0, 32'h0);
        do_reset();
        check32("flush_valid", 32'(out_valid_o), 32'd0);
        check32("flush_count", 32'(count_o), 32'd0);
        check32("flush_in_ready", 32'(in_ready_o), 32'd1);
        out_ready_i = 1'b1;
        drive(vt[3], 1'b0, 32'h0);
        check32("post_flush_addr", addr_o, 32'h0100_0000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/insn_encode.md
# insn_encode

Pipelined RISC-V RV32I instruction encoder, the inverse of the decode stage. It accepts decoded instruction fields over a valid/ready handshake, packs them into 32-bit instruction words, and tags each word with a sequential instruction-memory address. Results are buffered in a small FIFO and presented on a valid/ready output port. It sits in the test/boot infrastructure and feeds the instruction-memory write port when programs are assembled in hardware.

## Interface
- DWIDTH, 32, instruction word width
- AWIDTH, 32, address width
- BASE_ADDR, 32'h0100_0000, address counter reset value
- DEPTH, 4, output FIFO entries (power of two, ≥2)

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- in_valid_i  in  1  field set valid
- in_ready_o  out  1  field set accepted when high with in_valid_i
- opcode_i / rd_i / rs1_i / rs2_i  in  7/5/5/5  instruction fields
- funct3_i / funct7_i  in  3/7  function fields
- imm_i  in  DWIDTH  sign-extended immediate (shamt in imm_i[4:0])
- addr_load_i / addr_i  in  1/AWIDTH  reload the address counter
- out_valid_o  out  1  FIFO head valid
- out_ready_i  in  1  consumer accepts head
- insn_o / addr_o  out  DWIDTH/AWIDTH  encoded word and its address
- err_o  out  1  one-cycle pulse: rejected field set
- count_o  out  16  words popped, wraps modulo 2^16

## Operation
- Accept when in_valid_i && in_ready_o. in_ready_o = !full; there is no pass-through when the FIFO is full, even if a pop happens in the same cycle.
- Encoding by opcode:
  - R (0110011): f7|rs2|rs1|f3|rd|op.
  - I (0010011, 0000011, 1100111, 1110011): imm[11:0]|rs1|f3|rd|op.
  - Shift-immediates (op 0010011, f3 001/101): f7|imm[4:0]|rs1|f3|rd|op.
  - S (0100011): imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B (1100011): imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U (0110111, 0010111): imm[31:12]|rd|op.
  - J (1101111): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Unsupported opcode: the field set is consumed, nothing is pushed, err_o pulses, and the address counter is unchanged.
- Address counter:
  - Each pushed word takes the current counter value; the counter then advances by 4, wrapping modulo 2^AWIDTH.
  - addr_load_i sets the counter to addr_i.
  - If addr_load_i coincides with an accepted, pushed word, the word takes addr_i and the counter becomes addr_i+4.
- The FIFO preserves order. A push and a pop in the same cycle are both honoured when the FIFO is neither empty nor full.
- count_o increments on each out_valid_o && out_ready_i.

## Timing
- Reset values: FIFO empty, out_valid_o=0, in_ready_o=1, insn_o=0, addr_o=0, err_o=0, count_o=0, counter=BASE_ADDR.
- Latency: an accept in cycle N makes the word visible on out_valid_o in cycle N+1 when the FIFO was empty.
- err_o is registered: it is high in cycle N+1 for a rejection in cycle N.
- insn_o and addr_o are stable while out_valid_o && !out_ready_i.
- Reset asserted mid-stream flushes all entries at that edge; in-flight words are lost.

## Configuration
- IMM_CHECK_EN defined: the immediate is range-checked before encoding.
  - I/S: imm_i must equal sext(imm_i[11:0]).
  - B: imm_i must equal sext(imm_i[12:0]) with imm_i[0]=0.
  - J: imm_i must equal sext(imm_i[20:0]) with imm_i[0]=0.
  - U: imm_i[11:0] must be 0.
  - Shift-immediates: imm_i[31:5] must be 0.
  - A failure is treated exactly like an unsupported opcode.
- IMM_CHECK_EN undefined: immediates are silently truncated to the format's bits; err_o fires only on an unsupported opcode.

## Structure
- Shared package: opcode and funct3 constants (shared with decode), plus a typedef insn_fields_t (struct of opcode/rd/rs1/rs2/funct3/funct7/imm) and a typedef enc_entry_t {insn, addr}.
- Encoding logic is combinational and registered at the FIFO write.
- Sub-module insn_enc_fifo: a parameterised synchronous FIFO of enc_entry_t with push/pop/full/empty.

## Test plan
- add x3,x1,x2 (op 0110011, rd 3, rs1 1, rs2 2, f3 0, f7 0) -> insn_o 0x002081B3, addr_o 0x01000000, out_valid_o one cycle after accept.
- addi x1,x0,-1 (imm 0xFFFFFFFF), then beq x1,x2,+8 -> 0xFFF00093 @0x01000000, then 0x00208463 @0x01000004.
- jal x1,+2048 (imm 0x800) with addr_load_i=1, addr_i=0x0000FFFC -> 0x001000EF @0x0000FFFC; the next word lands @0x00010000.
- out_ready_i=0, push 5 words -> in_ready_o low after the 4th; the 5th is held. Raise out_ready_i -> order and addresses +0,+4,+8,+C,+10; count_o=5.
- opcode 0x7F -> err_o one-cycle pulse, no output, counter unchanged. addi imm 0x800: with IMM_CHECK_EN -> err_o pulse; without -> 0x80000093.
- Drive rst=0 for one edge with 3 queued words -> out_valid_o=0, count_o=0; the next word emits at 0x01000000.
